// File: rtl/xorshift_plus_gen.sv
// Parametrised xorshift+ generator with warm-up discard, zero-seed guard and an
// output FIFO drained through a valid/ready handshake.
module xorshift_plus_gen #(
  parameter int WIDTH  = 256,
  parameter int SH_A   = 23,
  parameter int SH_B   = 18,
  parameter int SH_C   = 5,
  parameter int WARMUP = 8,
  parameter int DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set,
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             seeded
);

  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int WCW = $clog2(WARMUP + 2);
  localparam logic [WCW-1:0] WLAST = WCW'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [CW-1:0]  FULL  = CW'(DEPTH);
  localparam logic [WIDTH-1:0] GUARD = {(WIDTH/64){64'h9E3779B97F4A7C15}};

  typedef enum logic [1:0] {ST_IDLE, ST_WARM, ST_RUN} state_e;

  function automatic logic [WIDTH-1:0] xs_sum(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
    return x + y;
  endfunction

  function automatic logic [WIDTH-1:0] xs_mix(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] t;
    t = x ^ (x << SH_A);
    return t ^ y ^ (t >> SH_B) ^ (y >> SH_C);
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] s0_q, s0_d, s1_q, s1_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             pop, space, step, push;

  always_comb begin
    state_d = state_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    wcnt_d  = wcnt_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    step    = 1'b0;
    push    = 1'b0;
    pop     = (cnt_q != '0) && out_ready;
    space   = (cnt_q != FULL) || pop;

    if (set) begin
      // Seed load wins over any push/pop in the same cycle
      if (seed0 == '0 && seed1 == '0) begin
        s0_d = GUARD;
        s1_d = '0;
      end else begin
        s0_d = seed0;
        s1_d = seed1;
      end
      state_d = (WARMUP == 0) ? ST_RUN : ST_WARM;
      wcnt_d  = '0;
      wptr_d  = '0;
      rptr_d  = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_WARM: begin
          step = 1'b1;
          if (wcnt_q == WLAST) state_d = ST_RUN;
          else                 wcnt_d  = wcnt_q + 1'b1;
        end
        ST_RUN: begin
          step = space;
          push = space;
        end
        default: ;
      endcase

      if (step) begin
        s0_d = s1_q;
        s1_d = xs_mix(s0_q, s1_q);
      end
      if (push) begin
        mem_d[wptr_q] = xs_sum(s0_q, s1_q);
        wptr_d        = wptr_q + 1'b1;
      end
      if (pop) rptr_d = rptr_q + 1'b1;

      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      s0_q    <= '0;
      s1_q    <= '0;
      wcnt_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      wcnt_q  <= wcnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage holds data only; emptiness is tracked by cnt_q, so no reset needed
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign out_valid = (cnt_q != '0);
  assign out_data  = out_valid ? mem_q[rptr_q] : '0;
  assign seeded    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_xorshift_plus_gen.sv
// Bench for xorshift_plus_gen: a 64-bit no-warm-up instance and a 256-bit
// instance with 8-step warm-up, both scored against a word-level reference.
module tb_xorshift_plus_gen;

  localparam logic [63:0] GOLD = 64'h9E3779B97F4A7C15;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic         set_a = 1'b0, rdy_a = 1'b0;
  logic [63:0]  s0_a = '0, s1_a = '0, dat_a;
  logic         vld_a, sd_a;
  logic         set_b = 1'b0, rdy_b = 1'b0;
  logic [255:0] s0_b = '0, s1_b = '0, dat_b;
  logic         vld_b, sd_b;

  xorshift_plus_gen #(.WIDTH(64), .SH_A(23), .SH_B(18), .SH_C(5), .WARMUP(0), .DEPTH(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .set(set_a), .seed0(s0_a), .seed1(s1_a),
    .out_data(dat_a), .out_valid(vld_a), .out_ready(rdy_a), .seeded(sd_a));

  xorshift_plus_gen #(.WIDTH(256), .SH_A(23), .SH_B(18), .SH_C(5), .WARMUP(8), .DEPTH(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .set(set_b), .seed0(s0_b), .seed1(s1_b),
    .out_data(dat_b), .out_valid(vld_b), .out_ready(rdy_b), .seeded(sd_b));

  int checks = 0;
  int failures = 0;
  logic [255:0] ma0, ma1, mb0, mb1;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] mask_of(input int w);
    return (w == 256) ? {256{1'b1}} : ((256'd1 << w) - 256'd1);
  endfunction

  // Reference: one xorshift+ step on w-bit words, returns the emitted result
  task automatic ref_next(inout logic [255:0] s0, inout logic [255:0] s1,
                          input int w, output logic [255:0] r);
    logic [255:0] m, x, y;
    m  = mask_of(w);
    r  = (s0 + s1) & m;
    x  = (s0 ^ (s0 << 23)) & m;
    y  = s1;
    s0 = y;
    s1 = (x ^ y ^ (x >> 18) ^ (y >> 5)) & m;
  endtask

  task automatic ref_seed(output logic [255:0] s0, output logic [255:0] s1,
                          input logic [255:0] a, input logic [255:0] b, input int w);
    if (a == '0 && b == '0) begin
      s0 = {4{GOLD}} & mask_of(w);
      s1 = '0;
    end else begin
      s0 = a;
      s1 = b;
    end
  endtask

  task automatic seed_a(input logic [63:0] a, input logic [63:0] b, input int hold);
    set_a = 1'b1; s0_a = a; s1_a = b;
    repeat (hold) tick();
    set_a = 1'b0;
    ref_seed(ma0, ma1, 256'(a), 256'(b), 64);
  endtask

  task automatic seed_b(input logic [255:0] a, input logic [255:0] b, input int hold);
    set_b = 1'b1; s0_b = a; s1_b = b;
    repeat (hold) tick();
    set_b = 1'b0;
    ref_seed(mb0, mb1, a, b, 256);
  endtask

  task automatic stream_a(input int n, input int pct);
    int got = 0, cyc = 0;
    logic stall = 1'b0;
    logic [63:0] held = '0;
    logic [255:0] r;
    while (got < n && cyc < n * 40 + 100) begin
      if (stall && vld_a) chk("a_hold", 256'(dat_a), 256'(held));
      rdy_a = (int'($urandom_range(99)) < pct);
      if (vld_a && rdy_a) begin
        ref_next(ma0, ma1, 64, r);
        chk("a_word", 256'(dat_a), r);
        got++;
      end
      stall = vld_a && !rdy_a;
      held  = dat_a;
      tick();
      cyc++;
    end
    chk("a_count", 256'(got), 256'(n));
  endtask

  task automatic stream_b(input int n, input int pct);
    int got = 0, cyc = 0;
    logic stall = 1'b0;
    logic [255:0] held = '0;
    logic [255:0] r;
    while (got < n && cyc < n * 40 + 100) begin
      if (stall && vld_b) chk("b_hold", dat_b, held);
      rdy_b = (int'($urandom_range(99)) < pct);
      if (vld_b && rdy_b) begin
        ref_next(mb0, mb1, 256, r);
        chk("b_word", dat_b, r);
        got++;
      end
      stall = vld_b && !rdy_b;
      held  = dat_b;
      tick();
      cyc++;
    end
    chk("b_count", 256'(got), 256'(n));
  endtask

  function automatic logic [255:0] rand256();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    logic [255:0] r;
    int w;

    // Power-on reset
    #1 rst_n = 1'b0;
    #1;
    chk("rst_vld_a", 256'(vld_a), 256'(0));
    chk("rst_dat_a", 256'(dat_a), 256'(0));
    chk("rst_sd_a",  256'(sd_a),  256'(0));
    chk("rst_sd_b",  256'(sd_b),  256'(0));
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_sd_a", 256'(sd_a), 256'(0));

    // Known seeds 1,2 with consumer always ready
    rdy_a = 1'b1;
    seed_a(64'd1, 64'd2, 1);
    chk("lat_vld_a", 256'(vld_a), 256'(0));
    chk("seeded_a",  256'(sd_a),  256'(1));
    tick();
    chk("lat_vld1_a", 256'(vld_a), 256'(1));
    chk("w0_const",   256'(dat_a), 256'(64'h3));
    tick();
    chk("w1_const",   256'(dat_a), 256'(64'h800025));

    // Same seeds, consumer stalled: FIFO fills, then drains without gaps
    rdy_a = 1'b0;
    seed_a(64'd1, 64'd2, 1);
    tick();
    chk("stall_vld_a", 256'(vld_a), 256'(1));
    chk("stall_w0",    256'(dat_a), 256'(64'h3));
    repeat (6) tick();
    chk("stall_hold",  256'(dat_a), 256'(64'h3));
    stream_a(20, 100);

    // Reseed with the FIFO full while the consumer is ready
    rdy_a = 1'b0;
    repeat (6) tick();
    rdy_a = 1'b1;
    seed_a({$urandom(), $urandom()}, {$urandom(), $urandom()}, 1);
    chk("flush_vld_a", 256'(vld_a), 256'(0));
    stream_a(40, 100);

    // Seed held high for several cycles, then random back-pressure
    seed_a({$urandom(), $urandom()}, {$urandom(), $urandom()}, 3);
    chk("hold_set_vld", 256'(vld_a), 256'(0));
    stream_a(200, 60);

    // All-zero seeds pick up the guard constant
    rdy_a = 1'b0;
    seed_a(64'd0, 64'd0, 1);
    tick();
    chk("guard_w0", 256'(dat_a), 256'(GOLD));
    stream_a(100, 70);

    // Wide instance with warm-up: first word is the 9th result
    rdy_b = 1'b0;
    seed_b(rand256(), rand256(), 1);
    chk("seeded_b", 256'(sd_b), 256'(1));
    chk("warm_vld_b", 256'(vld_b), 256'(0));
    repeat (8) ref_next(mb0, mb1, 256, r);
    w = 0;
    while (!vld_b && w < 30) begin
      tick();
      w++;
    end
    chk("warm_latency", 256'(w), 256'(9));
    stream_b(2000, 75);

    seed_b('0, '0, 1);
    repeat (8) ref_next(mb0, mb1, 256, r);
    stream_b(100, 50);

    // Asynchronous reset between edges with both FIFOs holding data
    rdy_a = 1'b0;
    rdy_b = 1'b0;
    repeat (12) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_vld_a", 256'(vld_a), 256'(0));
    chk("mid_rst_dat_a", 256'(dat_a), 256'(0));
    chk("mid_rst_sd_a",  256'(sd_a),  256'(0));
    chk("mid_rst_vld_b", 256'(vld_b), 256'(0));
    chk("mid_rst_dat_b", dat_b, 256'(0));
    chk("mid_rst_sd_b",  256'(sd_b),  256'(0));
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_vld_b", 256'(vld_b), 256'(0));
    chk("post_rst_sd_b",  256'(sd_b),  256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
